// File: rtl/jtag_dtm_pkg.sv
// Shared types and constants for the oversampled JTAG debug transport module.
package dtm_pkg;

  localparam int IR_W = 5;
  localparam int DR_W = 41;

  localparam logic [IR_W-1:0] IR_IDCODE = 5'h01;
  localparam logic [IR_W-1:0] IR_DTMCS  = 5'h10;
  localparam logic [IR_W-1:0] IR_DMI    = 5'h11;
  localparam logic [IR_W-1:0] IR_BYPASS = 5'h1f;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;
  localparam logic [1:0] DMI_OP_BUSY  = 2'd3;

  typedef enum logic [3:0] {
    TAP_TEST_LOGIC_RESET,
    TAP_RUN_TEST_IDLE,
    TAP_SELECT_DR,
    TAP_CAPTURE_DR,
    TAP_SHIFT_DR,
    TAP_EXIT1_DR,
    TAP_PAUSE_DR,
    TAP_EXIT2_DR,
    TAP_UPDATE_DR,
    TAP_SELECT_IR,
    TAP_CAPTURE_IR,
    TAP_SHIFT_IR,
    TAP_EXIT1_IR,
    TAP_PAUSE_IR,
    TAP_EXIT2_IR,
    TAP_UPDATE_IR
  } tap_state_e;

  // Which data register the current IR routes between TDI and TDO.
  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_DTMCS,
    DR_DMI
  } dr_sel_e;

  typedef struct packed {
    logic [13:0] zero_hi;
    logic        dmihardreset;
    logic        dmireset;
    logic        zero_mid;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

  typedef struct packed {
    logic [6:0]  address;
    logic [31:0] data;
    logic [1:0]  op;
  } dmi_scan_t;

  // IEEE 1149.1 TAP next-state function.
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_next = TAP_TEST_LOGIC_RESET;
    case (s)
      TAP_TEST_LOGIC_RESET: tap_next = tms ? TAP_TEST_LOGIC_RESET : TAP_RUN_TEST_IDLE;
      TAP_RUN_TEST_IDLE:    tap_next = tms ? TAP_SELECT_DR : TAP_RUN_TEST_IDLE;
      TAP_SELECT_DR:        tap_next = tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR:       tap_next = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:         tap_next = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:         tap_next = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:         tap_next = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:         tap_next = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:        tap_next = tms ? TAP_SELECT_DR : TAP_RUN_TEST_IDLE;
      TAP_SELECT_IR:        tap_next = tms ? TAP_TEST_LOGIC_RESET : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR:       tap_next = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:         tap_next = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:         tap_next = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:         tap_next = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:         tap_next = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:        tap_next = tms ? TAP_SELECT_DR : TAP_RUN_TEST_IDLE;
      default:              tap_next = TAP_TEST_LOGIC_RESET;
    endcase
  endfunction

endpackage

// File: rtl/jtag_dtm_if.sv
// DMI request/response bus between the DTM (master) and the debug module (slave).
interface jtag_dtm_if;
  logic        dmi_start;
  logic        dmi_finish;
  logic [1:0]  dmi_op;
  logic [31:0] dmi_data_o;
  logic [31:0] dmi_data_i;
  logic [6:0]  dmi_address;

  modport master (
    output dmi_start, dmi_op, dmi_data_o, dmi_address,
    input  dmi_finish, dmi_data_i
  );

  modport slave (
    input  dmi_start, dmi_op, dmi_data_o, dmi_address,
    output dmi_finish, dmi_data_i
  );
endinterface

// File: rtl/jtag_dtm_pin_sync.sv
// Oversamples raw JTAG pins into clk and produces single-cycle TCK edge strobes.
module jtag_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s
);

  logic [2:0] pins;
  logic [2:0] synced;
  logic       tck_hist_reg;

  assign pins = {tdi, tms, tck};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;

      // Two-flop synchronizer for one pin; equal depth keeps tms/tdi aligned with tck.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= pins[gi];
          sync_reg <= meta_reg;
        end
      end

      assign synced[gi] = sync_reg;
    end
  endgenerate

  // One cycle of synced tck history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tck_hist_reg <= 1'b0;
    else        tck_hist_reg <= synced[0];
  end

  assign tck_rise = synced[0] & ~tck_hist_reg;
  assign tck_fall = ~synced[0] & tck_hist_reg;
  assign tms_s    = synced[1];
  assign tdi_s    = synced[2];

endmodule

// File: rtl/jtag_dtm.sv
// RISC-V 0.13 JTAG DTM running entirely in the clk domain: TAP, IR, IDCODE,
// DTMCS, DMI and BYPASS registers, driving the debug module's DMI bus.
module jtag_dtm
  import dtm_pkg::*;
#(
  parameter logic [31:0] IDCODE = 32'h1000_0001,
  parameter int unsigned ABITS  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tck_i,
  input  logic              tms_i,
  input  logic              tdi_i,
  output logic              tdo_o,
  output logic              tdo_oe,
  jtag_dtm_if.master        dmi
);

  logic tck_rise, tck_fall, tms_s, tdi_s;

  jtag_pin_sync u_pin_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .tck      (tck_i),
    .tms      (tms_i),
    .tdi      (tdi_i),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s)
  );

  // TAP side state
  tap_state_e       state_reg;
  logic [IR_W-1:0]  ir_reg;
  logic [IR_W-1:0]  ir_shift_reg;
  logic [DR_W-1:0]  dr_shift_reg;
  logic             tdo_reg;
  logic             tdo_oe_reg;

  // DMI side state
  logic             busy_reg;
  logic             sticky_reg;
  logic             start_reg;
  logic [1:0]       op_reg;
  logic [6:0]       addr_reg;
  logic [31:0]      wdata_reg;
  logic [31:0]      rdata_reg;

  dr_sel_e          dr_sel;
  dtmcs_t           dtmcs_rd;
  dmi_scan_t        cap_dmi;
  dmi_scan_t        scan_in;
  logic [DR_W-1:0]  capture_value;
  logic [DR_W-1:0]  shift_value;
  logic             finish_hit;
  logic             busy_eff;
  logic [31:0]      rdata_eff;
  logic             capture_dmi;
  logic             update_dmi;
  logic             update_dtmcs;
  logic             req_op_valid;

  // Decode the selected DR; anything unrecognised falls back to BYPASS.
  always_comb begin
    dr_sel = DR_BYPASS;
    case (ir_reg)
      IR_IDCODE: dr_sel = DR_IDCODE;
      IR_DTMCS:  dr_sel = DR_DTMCS;
      IR_DMI:    dr_sel = DR_DMI;
      default:   dr_sel = DR_BYPASS;
    endcase
  end

  // A completion in this very cycle counts as already done, so a coincident
  // capture sees the fresh read data rather than a busy status.
  always_comb begin
    finish_hit = dmi.dmi_finish & busy_reg;
    busy_eff   = busy_reg & ~finish_hit;
    rdata_eff  = (finish_hit && op_reg == DMI_OP_READ) ? dmi.dmi_data_i : rdata_reg;
  end

  // Capture values for DTMCS and DMI.
  always_comb begin
    dtmcs_rd              = '0;
    dtmcs_rd.version      = 4'd1;
    dtmcs_rd.abits        = 6'(ABITS);
    dtmcs_rd.dmistat      = sticky_reg ? 2'd3 : 2'd0;
    dtmcs_rd.idle         = 3'd1;

    cap_dmi.address = addr_reg;
    cap_dmi.data    = rdata_eff;
    cap_dmi.op      = DMI_OP_NOP;
    if (busy_eff) begin
      cap_dmi.data = wdata_reg;
      cap_dmi.op   = DMI_OP_BUSY;
    end else if (sticky_reg) begin
      cap_dmi.op   = DMI_OP_BUSY;
    end

    capture_value = '0;
    case (dr_sel)
      DR_IDCODE: capture_value = {9'd0, IDCODE};
      DR_DTMCS:  capture_value = {9'd0, dtmcs_rd};
      DR_DMI:    capture_value = cap_dmi;
      default:   capture_value = '0;
    endcase
  end

  // Right shift with TDI entering at the top bit of the selected register length.
  always_comb begin
    shift_value = dr_shift_reg >> 1;
    case (dr_sel)
      DR_IDCODE, DR_DTMCS: shift_value[31]     = tdi_s;
      DR_DMI:              shift_value[DR_W-1] = tdi_s;
      default:             shift_value[0]      = tdi_s;
    endcase
  end

  // Qualified capture and update strobes seen by the DMI side.
  always_comb begin
    scan_in      = dmi_scan_t'(dr_shift_reg);
    capture_dmi  = tck_rise && state_reg == TAP_CAPTURE_DR && dr_sel == DR_DMI;
    update_dmi   = tck_fall && state_reg == TAP_UPDATE_DR  && dr_sel == DR_DMI;
    update_dtmcs = tck_fall && state_reg == TAP_UPDATE_DR  && dr_sel == DR_DTMCS;
    req_op_valid = scan_in.op == DMI_OP_READ || scan_in.op == DMI_OP_WRITE;
  end

  // TAP FSM: capture/shift on rise in the current state, update and TDO on fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= TAP_TEST_LOGIC_RESET;
      ir_reg       <= IR_IDCODE;
      ir_shift_reg <= '0;
      dr_shift_reg <= '0;
      tdo_reg      <= 1'b0;
      tdo_oe_reg   <= 1'b0;
    end else if (tck_rise) begin
      case (state_reg)
        TAP_CAPTURE_IR: ir_shift_reg <= 5'b00001;
        TAP_SHIFT_IR:   ir_shift_reg <= {tdi_s, ir_shift_reg[IR_W-1:1]};
        TAP_CAPTURE_DR: dr_shift_reg <= capture_value;
        TAP_SHIFT_DR:   dr_shift_reg <= shift_value;
        default: ;
      endcase
      state_reg <= tap_next(state_reg, tms_s);
      if (tap_next(state_reg, tms_s) == TAP_TEST_LOGIC_RESET) ir_reg <= IR_IDCODE;
    end else if (tck_fall) begin
      if (state_reg == TAP_UPDATE_IR) ir_reg <= ir_shift_reg;
      tdo_reg    <= (state_reg == TAP_SHIFT_IR) ? ir_shift_reg[0] :
                    (state_reg == TAP_SHIFT_DR) ? dr_shift_reg[0] : 1'b0;
      tdo_oe_reg <= (state_reg == TAP_SHIFT_IR) || (state_reg == TAP_SHIFT_DR);
    end
  end

  // DMI request tracking: issue, completion, busy/sticky bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg   <= 1'b0;
      sticky_reg <= 1'b0;
      start_reg  <= 1'b0;
      op_reg     <= DMI_OP_NOP;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
    end else begin
      start_reg <= 1'b0;
      if (finish_hit) begin
        busy_reg <= 1'b0;
        if (op_reg == DMI_OP_READ) rdata_reg <= dmi.dmi_data_i;
      end
      if (capture_dmi && busy_eff) sticky_reg <= 1'b1;
      if (update_dtmcs && (dr_shift_reg[16] || dr_shift_reg[17])) sticky_reg <= 1'b0;
      // Hard reset abandons the request; its late finish then finds us idle.
      if (update_dtmcs && dr_shift_reg[17]) busy_reg <= 1'b0;
      if (update_dmi && req_op_valid) begin
        if (busy_eff) begin
          sticky_reg <= 1'b1;
        end else if (!sticky_reg) begin
          addr_reg  <= scan_in.address;
          wdata_reg <= scan_in.data;
          op_reg    <= scan_in.op;
          start_reg <= 1'b1;
          busy_reg  <= 1'b1;
        end
      end
    end
  end

  assign tdo_o           = tdo_reg;
  assign tdo_oe          = tdo_oe_reg;
  assign dmi.dmi_start   = start_reg;
  assign dmi.dmi_op      = op_reg;
  assign dmi.dmi_data_o  = wdata_reg;
  assign dmi.dmi_address = addr_reg;

endmodule

// File: doc/jtag_dtm.md
Name: jtag_dtm

Overview:
JTAG Debug Transport Module, the upstream neighbour of the debug module. It drives the DM's trivial DMI bus: dmi_start, dmi_finish, op, 32-bit data and 7-bit address.
JTAG pins are oversampled in the clk domain, so the TAP, IR, DTMCS and DMI registers all run on clk. This removes any TCK clock domain, and dmi_start is natively synchronous to the DM.
Implements RISC-V Debug 0.13 DTM registers: IDCODE, DTMCS, DMI and BYPASS.

Parameters:
IDCODE, 32'h1000_0001, value returned by the IDCODE DR; bit 0 must be 1.
ABITS, 7, DMI address width; fixed at 7 to match the DM.

Ports:
clk  in  1  system clock; must be at least 8x TCK; TCK high and low phases each at least 3 clk periods.
rst_n  in  1  asynchronous reset, active-low.
tck_i  in  1  raw JTAG TCK, asynchronous to clk.
tms_i  in  1  raw JTAG TMS, asynchronous.
tdi_i  in  1  raw JTAG TDI, asynchronous.
tdo_o  out  1  JTAG TDO.
tdo_oe  out  1  TDO output enable; high only in Shift-IR and Shift-DR.
dmi_start  out  1  single-clk request pulse to the DM.
dmi_finish  in  1  DM completion pulse.
dmi_op  out  2  request op: 1 = read, 2 = write.
dmi_data_o  out  32 [33:2]  write data to the DM.
dmi_data_i  in  32 [33:2]  read data from the DM; valid while dmi_finish is high.
dmi_address  out  7 [40:34]  DM register address.

Behaviour:
- Reset values:
  - All outputs 0.
  - TAP in Test-Logic-Reset; IR = 5'h01 (IDCODE).
  - No request busy; sticky error cleared.
  - Captured DMI response = {addr 0, data 0, op 0}.
- Pin sync and edge detect:
  - tck, tms and tdi each pass through a 2-flop synchronizer, plus one flop of tck history for edge detect.
  - rise = one-clk pulse on a synced tck 0->1 transition; fall = one-clk pulse on a 1->0 transition.
  - tms and tdi are sampled from the synced copies in the rise cycle.
- TAP FSM:
  - 16 IEEE 1149.1 states; advances only in rise cycles, using synced tms.
  - TMS = 1 for 5 consecutive rises reaches Test-Logic-Reset from any state.
  - Entering Test-Logic-Reset sets IR = IDCODE.
- Rise-cycle actions, taken in the current state before the transition:
  - Capture-IR: ir_shift = 5'b00001.
  - Shift-IR: ir_shift = {tdi, ir_shift[4:1]}.
  - Capture-DR: load dr_shift from the selected register.
  - Shift-DR: shift dr_shift right with tdi into the MSB of the selected length.
- DR lengths: IDCODE 32, DTMCS 32, DMI 41, BYPASS 1.
  - IR values 5'h00 and any unknown IR select BYPASS (Capture loads 0).
- Fall-cycle actions:
  - Update-IR: IR = ir_shift.
  - Update-DR: commit the selected DR.
  - TDO = LSB of the active shift register while in Shift-IR/DR, else 0.
- DTMCS read value:
  - version [3:0] = 1; abits [9:4] = 7; dmistat [11:10] = 0 or 3 (sticky); idle [14:12] = 1; all other bits 0.
- DTMCS write (Update-DR):
  - bit 16 dmireset clears the sticky error.
  - bit 17 dmihardreset clears the sticky error and the busy flag, and drops the outstanding request. A later dmi_finish for that request is ignored.
- DMI Capture-DR:
  - If busy: load {address, data, op = 3} and set sticky.
  - Else if sticky: op = 3.
  - Else: load {last address, last read data, op 0}.
- DMI Update-DR, by the op field of the shifted value:
  - op 0 (nop): no request.
  - op 3: treated as nop.
  - op 1 or 2, while busy: set sticky; no request is issued.
  - op 1 or 2, while sticky (not busy): ignored.
  - op 1 or 2, otherwise:
    - latch address, data and op onto the dmi_* outputs;
    - dmi_start = 1 for exactly one clk, in the cycle after the fall cycle;
    - set busy.
- Request completion:
  - While busy, dmi_* outputs are held stable.
  - On dmi_finish: if op was read, latch dmi_data_i as the last read data; clear busy in the same cycle.
  - dmi_finish arriving while not busy is ignored.
- Simultaneous events:
  - dmi_finish in the same cycle as a DMI Capture-DR: capture sees not-busy and takes the fresh data.
  - Write address outputs are not cleared after completion.
- rst_n asserted mid-request: immediate return to reset values; dmi_start never glitches high.

Decomposition:
- Package dtm_pkg:
  - tap_state_e (16 states);
  - IR constants IR_IDCODE = 5'h01, IR_DTMCS = 5'h10, IR_DMI = 5'h11, IR_BYPASS = 5'h1f;
  - dtmcs_t packed struct;
  - dmi_scan_t packed struct {address[6:0], data[31:0], op[1:0]}; DMI_OP_NOP, DMI_OP_READ, DMI_OP_WRITE, DMI_OP_BUSY.
- Sub-module jtag_pin_sync: 2-flop synchronizers plus tck edge detect; outputs tck_rise, tck_fall, tms_s, tdi_s. Reused by any future pin-oversampled TAP.

Test Plan:
1. Reset, then 32 Shift-DR clocks with the default IR -> TDO streams 0x10000001 LSB-first; tdo_oe high only in Shift-DR.
2. IR = 0x10, then DR scan of 32 bits -> reads 0x00001071.
3. IR = 0x11, shift {addr 0x10, data 0x00000001, op 2} -> exactly one dmi_start pulse with address 0x10, data 0x1, op 2; the next scan captures op 0.
4. DM model returns 0x00400C82 for a read of address 0x11; issue the read scan, then a nop scan -> captured {0x11, 0x00400C82, 0}.
5. Hold dmi_finish low for 200 clk and issue a second write scan -> no second dmi_start; the capture shows op 3, DTMCS dmistat = 3. Then write DTMCS with bit 16 set -> dmistat = 0; a new request starts normally.
6. Pulse rst_n low while busy -> all outputs 0, TAP in Test-Logic-Reset, IR = 0x01; a dmi_finish pulse after reset is ignored (no state change).
